// File: rtl/ysyx_23060072_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encodings, default reset PC and bubble
// instruction, and the word-alignment helper used on redirect targets.
package ysyx_23060072_fetch_ctrl_pkg;

  localparam logic [1:0] FETCH_BOOT = 2'd0;
  localparam logic [1:0] FETCH_RUN  = 2'd1;
  localparam logic [1:0] FETCH_HALT = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060072_if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, otherwise all fields hold.
module ysyx_23060072_if_id_reg
  import ysyx_23060072_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        misalign_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        id_misalign_o
);

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic        misalign_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= 32'h0;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (flush_i) begin
      // The bubble keeps the old PC tag; only the payload and flags are killed.
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (load_i) begin
      pc_q       <= pc_i;
      inst_q     <= inst_i;
      valid_q    <= 1'b1;
      misalign_q <= misalign_i;
    end
  end

  assign id_pc_o       = pc_q;
  assign id_inst_o     = inst_q;
  assign id_valid_o    = valid_q;
  assign id_misalign_o = misalign_q;

endmodule

// File: rtl/ysyx_23060072_fetch_ctrl.sv
// Fetch control: PC register, BOOT/RUN/HALT FSM and IF/ID register.
// Optional performance counters are built when YSYX_23060072_FETCH_PERF_EN is defined.
module ysyx_23060072_fetch_ctrl
  import ysyx_23060072_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        id_misalign_o,
`ifdef YSYX_23060072_FETCH_PERF_EN
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_flush_o,
`endif
  output logic        halted_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic        ifid_load;
  logic        ifid_flush;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (halt_i) begin
          state_d    = FETCH_HALT;
          ifid_flush = 1'b1;
        end else if (redirect_i) begin
          pc_d       = align_word(redirect_pc_i);
          pend_d     = |redirect_pc_i[1:0];
          ifid_flush = 1'b1;
        end else if (!stall_i) begin
          pc_d      = pc_q + 32'd4;
          pend_d    = 1'b0;
          ifid_load = 1'b1;
        end
      end
      default: ;  // HALT (and the unused encoding) freeze everything
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Straight from the register: the IFU address never depends on EX this cycle.
  assign instr_addr_o = pc_q;
  assign halted_o     = (state_q == FETCH_HALT);

  ysyx_23060072_if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (ifid_load),
    .flush_i       (ifid_flush),
    .pc_i          (pc_q),
    .inst_i        (inst_rdata_i),
    .misalign_i    (pend_q),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_valid_o    (id_valid_o),
    .id_misalign_o (id_misalign_o)
  );

`ifdef YSYX_23060072_FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic        in_run;

  assign in_run = (state_q == FETCH_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      if (ifid_load)                          perf_fetch_q <= perf_fetch_q + 32'd1;
      if (in_run && stall_i && !redirect_i)   perf_stall_q <= perf_stall_q + 32'd1;
      if (in_run && !halt_i && redirect_i)    perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_ysyx_23060072_fetch_ctrl.sv
// Directed bench for ysyx_23060072_fetch_ctrl with a small combinational ROM model.
module tb_ysyx_23060072_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic [31:0] instr_addr_o;
  logic [31:0] inst_rdata_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        id_misalign_o;
  logic        halted_o;
`ifdef YSYX_23060072_FETCH_PERF_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_stall_o;
  logic [31:0] perf_flush_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0093 : {a[15:0], 16'h0013};
  endfunction

  assign inst_rdata_i = rom(instr_addr_o);

  ysyx_23060072_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .instr_addr_o  (instr_addr_o),
    .inst_rdata_i  (inst_rdata_i),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_valid_o    (id_valid_o),
    .id_misalign_o (id_misalign_o),
`ifdef YSYX_23060072_FETCH_PERF_EN
    .perf_fetch_o  (perf_fetch_o),
    .perf_stall_o  (perf_stall_o),
    .perf_flush_o  (perf_flush_o),
`endif
    .halted_o      (halted_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid, input logic mis);
    check({tag, ".id_pc"}, id_pc_o, pc);
    check({tag, ".id_inst"}, id_inst_o, inst);
    check({tag, ".id_valid"}, {31'h0, id_valid_o}, {31'h0, valid});
    check({tag, ".id_mis"}, {31'h0, id_misalign_o}, {31'h0, mis});
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; halt_i = 1'b0;
    #12;
    check("rst.addr", instr_addr_o, 32'h8000_0000);
    check_ifid("rst", 32'h0, NOP, 1'b0, 1'b0);
    check("rst.halted", {31'h0, halted_o}, 32'h0);

    // BOOT cycle ignores all requests.
    @(negedge clk);
    rst_n = 1'b1; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100; halt_i = 1'b1;
    step();
    check("boot.addr", instr_addr_o, 32'h8000_0000);
    check("boot.valid", {31'h0, id_valid_o}, 32'h0);
    check("boot.halted", {31'h0, halted_o}, 32'h0);
    stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;

    // Free run: first fetch, then PC steps by 4.
    step();
    check_ifid("run0", 32'h8000_0000, 32'h0010_0093, 1'b1, 1'b0);
    check("run0.addr", instr_addr_o, 32'h8000_0004);
    step();
    check_ifid("run1", 32'h8000_0004, 32'h0004_0013, 1'b1, 1'b0);
    check("run1.addr", instr_addr_o, 32'h8000_0008);
    step();
    step();
    check("run3.addr", instr_addr_o, 32'h8000_0010);
    check("run3.id_pc", id_pc_o, 32'h8000_000C);

    // Three-cycle stall at pc 0x8000_0010.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.addr", instr_addr_o, 32'h8000_0010);
      check_ifid("stall", 32'h8000_000C, 32'h000C_0013, 1'b1, 1'b0);
    end
    stall_i = 1'b0;
    step();
    check_ifid("unstall", 32'h8000_0010, 32'h0010_0013, 1'b1, 1'b0);
    check("unstall.addr", instr_addr_o, 32'h8000_0014);

    // Redirect wins over a simultaneous stall.
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0040;
    step();
    stall_i = 1'b0; redirect_i = 1'b0;
    check("redir.addr", instr_addr_o, 32'h8000_0040);
    check("redir.valid", {31'h0, id_valid_o}, 32'h0);
    check("redir.inst", id_inst_o, NOP);
    step();
    check_ifid("redir.next", 32'h8000_0040, 32'h0040_0013, 1'b1, 1'b0);

    // Misaligned redirect: flag only on the first instruction.
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0042;
    step();
    redirect_i = 1'b0;
    check("mis.addr", instr_addr_o, 32'h8000_0040);
    check("mis.valid", {31'h0, id_valid_o}, 32'h0);
    step();
    check_ifid("mis.first", 32'h8000_0040, 32'h0040_0013, 1'b1, 1'b1);
    step();
    check_ifid("mis.second", 32'h8000_0044, 32'h0044_0013, 1'b1, 1'b0);

    // Pending flag survives a stall.
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0047;
    step();
    redirect_i = 1'b0; stall_i = 1'b1;
    step();
    check("mis_stall.valid", {31'h0, id_valid_o}, 32'h0);
    stall_i = 1'b0;
    step();
    check_ifid("mis_stall", 32'h8000_0044, 32'h0044_0013, 1'b1, 1'b1);

    // An aligned redirect clears a pending flag.
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_004A;
    step();
    redirect_pc_i = 32'h8000_0050;
    step();
    redirect_i = 1'b0;
    step();
    check_ifid("mis_clear", 32'h8000_0050, 32'h0050_0013, 1'b1, 1'b0);

    // PC wrap-around at the top of the address space.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    step();
    check_ifid("wrap", 32'hFFFF_FFFC, 32'hFFFC_0013, 1'b1, 1'b0);
    check("wrap.addr", instr_addr_o, 32'h0000_0000);

    // Halt at pc 0x8000_0020.
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_001C;
    step();
    redirect_i = 1'b0;
    step();
    check("pre_halt.addr", instr_addr_o, 32'h8000_0020);
    check("pre_halt.valid", {31'h0, id_valid_o}, 32'h1);
    halt_i = 1'b1;
    step();
    check("halt.halted", {31'h0, halted_o}, 32'h1);
    check("halt.valid", {31'h0, id_valid_o}, 32'h0);
    check("halt.addr", instr_addr_o, 32'h8000_0020);
    for (int i = 0; i < 10; i++) begin
      halt_i = i[0]; stall_i = ~i[0]; redirect_i = 1'b1; redirect_pc_i = 32'h1234_5678;
      step();
      check("halted.addr", instr_addr_o, 32'h8000_0020);
      check("halted.halted", {31'h0, halted_o}, 32'h1);
      check("halted.valid", {31'h0, id_valid_o}, 32'h0);
    end
    halt_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("areset.addr", instr_addr_o, 32'h8000_0000);
    check("areset.halted", {31'h0, halted_o}, 32'h0);
    check_ifid("areset", 32'h0, NOP, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();  // BOOT

`ifdef YSYX_23060072_FETCH_PERF_EN
    for (int i = 0; i < 5; i++) step();
    stall_i = 1'b1;
    step();
    step();
    stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    step();
    redirect_i = 1'b0; halt_i = 1'b1;
    step();
    halt_i = 1'b0; stall_i = 1'b1;
    step();
    stall_i = 1'b0;
    check("perf.fetch", perf_fetch_o, 32'd5);
    check("perf.stall", perf_stall_o, 32'd2);
    check("perf.flush", perf_flush_o, 32'd1);
`else
    step();
    check("post_reset.id_pc", id_pc_o, 32'h8000_0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
